cam_capture_seq: RTL and testbench

Sequencer between the camera APB3 control registers and the MIPI/DMA capture datapath.
- Brings the camera up: holds MIPI in reset for a fixed period, then waits for DMA init.
- Issues per-frame DMA start commands aligned to camera frame start, in single-shot or continuous mode.
- Supervises each capture with a timeout.
- Produces frame count, frames-per-second and state/error status for register readback.

---
 rtl/cam_capture_seq.sv | 118 +++++++++++
 tb/tb_cam_capture_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cam_capture_seq.sv
// cam_capture_seq: camera bring-up, per-frame DMA sequencing, timeout supervision and fps status
module cam_capture_seq #(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int RST_HOLD_CYC = 1024,
  parameter int TIMEOUT_CYC  = 16777216,
  parameter int FRAME_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_enable,
  input  logic                   cfg_continuous,
  input  logic                   cfg_trigger,
  input  logic                   dma_init_done,
  input  logic                   frame_start,
  input  logic                   dma_done,
  output logic                   mipi_rstn,
  output logic                   dma_start,
  output logic                   dma_abort,
  output logic                   capture_active,
  output logic                   timeout_err,
  output logic [2:0]             state,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [31:0]            frames_per_second
);
  localparam int HW = $clog2(RST_HOLD_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int WW = $clog2(CLK_FREQ_HZ + 1);
  typedef enum logic [2:0] {
    OFF = 3'd0, RST_HOLD = 3'd1, WAIT_INIT = 3'd2, IDLE = 3'd3,
    ARM = 3'd4, CAPTURE = 3'd5, ERROR = 3'd6
  } st_t;
  st_t cur, nxt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic [WW-1:0] win_cnt;
  logic [31:0] ev_cnt;
  logic trig_q, trig_ev, expired;
  logic mipi_d, start_d, abort_d, act_d, terr_d;
  assign trig_ev = cfg_trigger & ~trig_q;
  assign expired = to_cnt == '0;
  assign state = cur;
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cur <= OFF;
    else cur <= nxt;
  // next state; a dropped enable wins over everything, completion wins over expiry
  always_comb begin
    nxt = cur;
    if (!cfg_enable) nxt = OFF;
    else
      case (cur)
        OFF:       nxt = RST_HOLD;
        RST_HOLD:  nxt = hold_cnt == '0 ? WAIT_INIT : RST_HOLD;
        WAIT_INIT: nxt = dma_init_done ? IDLE : WAIT_INIT;
        IDLE:      nxt = (trig_ev | cfg_continuous) ? ARM : IDLE;
        ARM:       nxt = frame_start ? CAPTURE : expired ? ERROR : ARM;
        CAPTURE:   nxt = dma_done ? (cfg_continuous ? ARM : IDLE) : expired ? ERROR : CAPTURE;
        ERROR:     nxt = ERROR;
        default:   nxt = OFF;
      endcase
  end
  // next values of the registered outputs
  always_comb begin
    mipi_d  = cur inside {WAIT_INIT, IDLE, ARM, CAPTURE};
    start_d = cur == ARM && nxt == CAPTURE;
    abort_d = cur == CAPTURE && (nxt == OFF || nxt == ERROR);
    act_d   = nxt == ARM || nxt == CAPTURE;
    terr_d  = nxt == ERROR ? 1'b1 : nxt == OFF ? 1'b0 : timeout_err;
  end
  // output registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mipi_rstn      <= 1'b0;
      dma_start      <= 1'b0;
      dma_abort      <= 1'b0;
      capture_active <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      mipi_rstn      <= mipi_d;
      dma_start      <= start_d;
      dma_abort      <= abort_d;
      capture_active <= act_d;
      timeout_err    <= terr_d;
    end
  // MIPI reset hold countdown and trigger edge register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      hold_cnt <= '0;
      trig_q   <= 1'b0;
    end else begin
      trig_q <= cfg_trigger;
      if (cur == OFF && nxt == RST_HOLD) hold_cnt <= HW'(RST_HOLD_CYC - 1);
      else if (cur == RST_HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  // capture timeout: reloaded on every entry to ARM or CAPTURE
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) to_cnt <= '0;
    else if ((nxt == ARM || nxt == CAPTURE) && nxt != cur) to_cnt <= TW'(TIMEOUT_CYC - 1);
    else if ((cur == ARM || cur == CAPTURE) && !expired) to_cnt <= to_cnt - 1'b1;
  // completed-frame counter, wraps naturally
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) frame_count <= '0;
    else if (cur == CAPTURE && dma_done && cfg_enable) frame_count <= frame_count + 1'b1;
  // free-running fps window, independent of enable
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      win_cnt           <= '0;
      ev_cnt            <= '0;
      frames_per_second <= '0;
    end else if (win_cnt == WW'(CLK_FREQ_HZ - 1)) begin
      win_cnt           <= '0;
      ev_cnt            <= '0;
      frames_per_second <= ev_cnt + 32'(dma_done);
    end else begin
      win_cnt <= win_cnt + 1'b1;
      if (dma_done) ev_cnt <= ev_cnt + 1'b1;
    end
endmodule

// File: tb/tb_cam_capture_seq.sv
// tb_cam_capture_seq: directed checks of bring-up, capture modes, timeout, collisions and fps
module tb_cam_capture_seq;
  logic clk = 0, resetn = 0, cfg_enable = 0, cfg_continuous = 0, cfg_trigger = 0;
  logic dma_init_done = 0, frame_start = 0, dma_done = 0;
  logic mipi_rstn, dma_start, dma_abort, capture_active, timeout_err;
  logic [2:0] state;
  logic [1:0] frame_count;
  logic [31:0] frames_per_second;
  logic [1:0] exp_fc = 0;
  int checks = 0, failures = 0, ecnt = 0;
  always #5 clk = ~clk;
  cam_capture_seq #(.CLK_FREQ_HZ(100), .RST_HOLD_CYC(8), .TIMEOUT_CYC(16), .FRAME_CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .cfg_enable(cfg_enable), .cfg_continuous(cfg_continuous),
    .cfg_trigger(cfg_trigger), .dma_init_done(dma_init_done), .frame_start(frame_start),
    .dma_done(dma_done), .mipi_rstn(mipi_rstn), .dma_start(dma_start), .dma_abort(dma_abort),
    .capture_active(capture_active), .timeout_err(timeout_err), .state(state),
    .frame_count(frame_count), .frames_per_second(frames_per_second)
  );
  // edges since reset release, mirrors the fps window position
  always @(posedge clk or negedge resetn)
    if (!resetn) ecnt <= 0;
    else ecnt <= ecnt + 1;
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic test_reset;
    #2;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if ({mipi_rstn, dma_start, dma_abort, capture_active, timeout_err} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {mipi_rstn, dma_start, dma_abort, capture_active, timeout_err}); end
    checks++; if (frame_count !== 2'd0 || frames_per_second !== 32'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", frame_count, frames_per_second); end
    @(posedge clk); #1;
    resetn = 1;
  endtask
  task automatic test_bring_up;
    cfg_enable = 1;
    step();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL bu_hold got=%0d exp=1", state); end
    step(8);
    checks++; if (state !== 3'd2 || mipi_rstn !== 1'b0) begin failures++; $display("FAIL bu_pre_rise got=%0d/%b exp=2/0", state, mipi_rstn); end
    step();
    checks++; if (mipi_rstn !== 1'b1) begin failures++; $display("FAIL bu_rise got=%b exp=1", mipi_rstn); end
    step(3);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL bu_wait_init got=%0d exp=2", state); end
    dma_init_done = 1;
    step();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL bu_idle got=%0d exp=3", state); end
  endtask
  task automatic bring_up;
    cfg_enable = 1;
    for (int i = 0; i < 40 && state !== 3'd3; i++) step();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL bring_up_ready got=%0d exp=3", state); end
  endtask
  task automatic test_single_shot;
    cfg_trigger = 1;
    step();
    checks++; if (state !== 3'd4 || capture_active !== 1'b1) begin failures++; $display("FAIL ss_arm got=%0d/%b exp=4/1", state, capture_active); end
    frame_start = 1; step(); frame_start = 0;
    checks++; if (state !== 3'd5 || dma_start !== 1'b1) begin failures++; $display("FAIL ss_start got=%0d/%b exp=5/1", state, dma_start); end
    step();
    checks++; if (dma_start !== 1'b0) begin failures++; $display("FAIL ss_start_pulse got=%b exp=0", dma_start); end
    dma_done = 1; step(); dma_done = 0; exp_fc++;
    checks++; if (state !== 3'd3 || frame_count !== exp_fc || capture_active !== 1'b0) begin failures++; $display("FAIL ss_done got=%0d/%0d/%b exp=3/%0d/0", state, frame_count, capture_active, exp_fc); end
    step(3);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL ss_no_retrigger got=%0d exp=3", state); end
    cfg_trigger = 0;
  endtask
  task automatic test_continuous;
    int starts = 0;
    cfg_continuous = 1;
    step();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL ct_arm got=%0d exp=4", state); end
    for (int i = 0; i < 3; i++) begin
      frame_start = 1; step(); frame_start = 0;
      if (dma_start === 1'b1) starts++;
      step(2);
      dma_done = 1; step(); dma_done = 0; exp_fc++;
      checks++; if (frame_count !== exp_fc || state !== 3'd4) begin failures++; $display("FAIL ct_frame%0d got=%0d/%0d exp=%0d/4", i, frame_count, state, exp_fc); end
    end
    checks++; if (starts != 3) begin failures++; $display("FAIL ct_starts got=%0d exp=3", starts); end
    checks++; if (frame_count !== 2'd0) begin failures++; $display("FAIL ct_wrap got=%0d exp=0", frame_count); end
  endtask
  task automatic test_timeout;
    cfg_continuous = 0;
    frame_start = 1; step(); frame_start = 0;
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL to_capture got=%0d exp=5", state); end
    step(15);
    checks++; if (state !== 3'd5 || dma_abort !== 1'b0) begin failures++; $display("FAIL to_pre got=%0d/%b exp=5/0", state, dma_abort); end
    step();
    checks++; if (state !== 3'd6 || dma_abort !== 1'b1 || timeout_err !== 1'b1 || capture_active !== 1'b0) begin failures++; $display("FAIL to_expire got=%0d/%b/%b/%b exp=6/1/1/0", state, dma_abort, timeout_err, capture_active); end
    step();
    checks++; if (dma_abort !== 1'b0 || mipi_rstn !== 1'b0 || state !== 3'd6) begin failures++; $display("FAIL to_error got=%b/%b/%0d exp=0/0/6", dma_abort, mipi_rstn, state); end
    cfg_enable = 0; step();
    checks++; if (state !== 3'd0 || timeout_err !== 1'b0 || mipi_rstn !== 1'b0) begin failures++; $display("FAIL to_off got=%0d/%b/%b exp=0/0/0", state, timeout_err, mipi_rstn); end
  endtask
  task automatic test_collisions;
    bring_up();
    cfg_trigger = 0; step(); cfg_trigger = 1; step();
    frame_start = 1; step(); frame_start = 0;
    step(15);
    dma_done = 1; step(); dma_done = 0; exp_fc++;
    checks++; if (state !== 3'd3 || timeout_err !== 1'b0 || dma_abort !== 1'b0 || frame_count !== exp_fc) begin failures++; $display("FAIL col_done_wins got=%0d/%b/%b/%0d exp=3/0/0/%0d", state, timeout_err, dma_abort, frame_count, exp_fc); end
    cfg_trigger = 0; step(); cfg_trigger = 1; step(); cfg_trigger = 0;
    frame_start = 1; step(); frame_start = 0;
    step(2);
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL col_in_capture got=%0d exp=5", state); end
    cfg_enable = 0; step();
    checks++; if (state !== 3'd0 || dma_abort !== 1'b1 || dma_start !== 1'b0) begin failures++; $display("FAIL col_disable got=%0d/%b/%b exp=0/1/0", state, dma_abort, dma_start); end
    step();
    checks++; if (dma_abort !== 1'b0) begin failures++; $display("FAIL col_abort_pulse got=%b exp=0", dma_abort); end
    bring_up();
    cfg_trigger = 1; step(); cfg_trigger = 0;
    checks++; if (state !== 3'd4 || mipi_rstn !== 1'b1) begin failures++; $display("FAIL col_arm got=%0d/%b exp=4/1", state, mipi_rstn); end
    #2 resetn = 0;
    #1;
    checks++; if (state !== 3'd0 || {mipi_rstn, dma_start, dma_abort, capture_active, timeout_err} !== 5'b0 || frame_count !== 2'd0) begin failures++; $display("FAIL col_async_rst got=%0d/%b/%0d exp=0/00000/0", state, {mipi_rstn, dma_start, dma_abort, capture_active, timeout_err}, frame_count); end
    exp_fc = 0;
    cfg_enable = 0;
  endtask
  task automatic test_fps;
    @(posedge clk); #1;
    resetn = 1;
    while (ecnt < 200) begin
      dma_done = ecnt inside {9, 19, 29, 39, 99, 150, 160};
      step();
      dma_done = 0;
      if (ecnt == 99) begin checks++; if (frames_per_second !== 32'd0) begin failures++; $display("FAIL fps_before got=%0d exp=0", frames_per_second); end end
      if (ecnt == 100) begin checks++; if (frames_per_second !== 32'd5) begin failures++; $display("FAIL fps_window1 got=%0d exp=5", frames_per_second); end end
      if (ecnt == 199) begin checks++; if (frames_per_second !== 32'd5) begin failures++; $display("FAIL fps_hold got=%0d exp=5", frames_per_second); end end
      if (ecnt == 200) begin checks++; if (frames_per_second !== 32'd2) begin failures++; $display("FAIL fps_window2 got=%0d exp=2", frames_per_second); end end
    end
    checks++; if (frame_count !== 2'd0 || state !== 3'd0) begin failures++; $display("FAIL fps_off_no_count got=%0d/%0d exp=0/0", frame_count, state); end
  endtask
  initial begin
    test_reset();
    test_bring_up();
    test_single_shot();
    test_continuous();
    test_timeout();
    test_collisions();
    test_fps();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
